td4_sequencer: RTL
==================

# td4_sequencer

Multi-cycle fetch/execute control unit for the TD4-class CPU. It replaces the purely combinational opcode decoder. It owns the program counter, instruction register and carry flag, and fetches instructions over a request/acknowledge memory handshake. It drives the datapath mux select and the active-low register load strobes for one EXEC cycle per instruction. Width is parametrised and illegal opcodes trap.

## Interface
- DATA_W, 4, register/immediate width; instruction word is {op[3:0], imm[DATA_W-1:0]}
- PC_W, 4, program counter width

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request
- imem_addr  out  PC_W  fetch address (current PC)
- imem_ack  in  1  fetch data valid
- imem_data  in  4+DATA_W  instruction word
- carry_i  in  1  adder carry-out from datapath
- sel  out  2  source mux: 00 A, 01 B, 10 IN port, 11 zero
- ld_n  out  4  active-low loads: [0] A, [1] B, [2] OUT, [3] PC (informative; PC is internal)
- imm  out  DATA_W  immediate field of IR
- carry_o  out  1  carry flag register
- retire_o  out  1  one-cycle pulse in each EXEC cycle
- illegal_o  out  1  sticky illegal-opcode trap flag
- step_i  in  1  present only with TD4_SINGLE_STEP_EN

## Operation
- States: BOOT, FETCH, EXEC, TRAP, plus WAIT_STEP (macro only).
- BOOT: entered on reset; moves to FETCH after one cycle.
- FETCH: imem_req=1, imem_addr=pc. On imem_ack=1, IR <= imem_data and the next state is EXEC. imem_ack outside FETCH is ignored.
- EXEC: decode IR.op, assert sel/ld_n for exactly this cycle, retire_o=1, update PC and carry; the next state is FETCH.
- Opcode map (op → sel, ld_n):
  - 0000 ADD A,Im → 00, 1110
  - 0001 MOV A,B → 01, 1110
  - 0010 IN A → 10, 1110
  - 0011 MOV A,Im → 11, 1110
  - 0100 MOV B,A → 00, 1101
  - 0101 ADD B,Im → 01, 1101
  - 0110 IN B → 10, 1101
  - 0111 MOV B,Im → 11, 1101
  - 1001 OUT B → 01, 1011
  - 1011 OUT Im → 11, 1011
  - 1110 JNC Im → 11, 0111 if carry_o=0, else 1111
  - 1111 JMP Im → 11, 0111
- Illegal opcodes (1000, 1010, 1100, 1101): in EXEC, ld_n=1111 and retire_o=0. The next state is TRAP and illegal_o=1. TRAP holds, with imem_req=0, until reset.
- Carry: ADD opcodes (0000, 0101) set carry_o <= carry_i. All other legal opcodes clear carry_o to 0, because the datapath adds zero. JNC tests the carry value from before EXEC.
- PC update:
  - A taken jump loads pc <= imm, zero-extended or truncated to PC_W.
  - Otherwise pc <= pc+1 modulo 2^PC_W, so 2^PC_W−1 wraps to 0.
- Outside EXEC: sel=11, ld_n=1111, retire_o=0.

## Timing
- Reset values: imem_req 0, imem_addr 0, sel 11, ld_n 1111, imm 0, carry_o 0, retire_o 0, illegal_o 0, state BOOT.
- Minimum 2 cycles per instruction: FETCH with ack in the same cycle, then EXEC.
- imem_addr is stable and imem_req stays high from FETCH entry until the ack cycle.
- pc and carry_o take their new values on the clock edge that ends EXEC.
- Reset asserted at any point, including mid-FETCH or EXEC, forces all reset values immediately. A pending ack is discarded.
- All outputs are registered or decoded from registered IR/state; there is no combinational path from imem_ack or carry_i to any output.

## Configuration
- TD4_SINGLE_STEP_EN defined:
  - Adds the step_i port.
  - EXEC goes to WAIT_STEP instead of FETCH.
  - WAIT_STEP goes to FETCH on a cycle with step_i=1.
  - Outputs in WAIT_STEP match FETCH-idle values, with imem_req=0.
- Undefined: no step_i port, and EXEC goes directly to FETCH.

## Structure
- Package td4_pkg:
  - opcode localparams
  - state enum
  - sel encodings (SEL_A, SEL_B, SEL_IN, SEL_ZERO)
  - ld_n bit indices
- Sub-module td4_op_decode: combinational decoder from (op, carry) to sel, ld_n, legal, writes_carry, jump_taken. The FSM, PC, IR and carry registers stay in td4_sequencer.

## Test plan
- Reset, then ADD A,3 (0x03) with immediate ack → EXEC with sel=00, ld_n=1110, imm=3; pc=1; carry_o=carry_i.
- ADD A,1 with carry_i=1, then JNC 5 → ld_n=1111, pc increments. Then MOV A,Im (carry cleared), then JNC 5 → ld_n=0111, pc=5.
- PC_W=4, JMP 14, then two sequential instructions → fetch addresses 14, 15, 0.
- imem_ack delayed 3 cycles → imem_req held high with imem_addr constant; ld_n=1111 and retire_o=0 until EXEC.
- Opcode 1010 → illegal_o=1, imem_req=0 forever, no ld_n assertion. Reset clears to BOOT with pc=0.
- Reset asserted during EXEC → ld_n=1111 immediately, pc=0, carry_o=0. With TD4_SINGLE_STEP_EN, no second fetch occurs until step_i=1.

Source files
------------

// File: rtl/td4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : td4_pkg
// Description : Shared opcodes, state encoding, source-mux encodings and
//               load-strobe bit positions for the TD4 sequencer.
//               TD4_SINGLE_STEP_EN adds the WAIT_STEP state.
// Revision    : 1.0 - initial release
// ============================================================================
package td4_pkg;

  // Opcode map
  localparam logic [3:0] OP_ADD_A_IM = 4'b0000;
  localparam logic [3:0] OP_MOV_A_B  = 4'b0001;
  localparam logic [3:0] OP_IN_A     = 4'b0010;
  localparam logic [3:0] OP_MOV_A_IM = 4'b0011;
  localparam logic [3:0] OP_MOV_B_A  = 4'b0100;
  localparam logic [3:0] OP_ADD_B_IM = 4'b0101;
  localparam logic [3:0] OP_IN_B     = 4'b0110;
  localparam logic [3:0] OP_MOV_B_IM = 4'b0111;
  localparam logic [3:0] OP_OUT_B    = 4'b1001;
  localparam logic [3:0] OP_OUT_IM   = 4'b1011;
  localparam logic [3:0] OP_JNC_IM   = 4'b1110;
  localparam logic [3:0] OP_JMP_IM   = 4'b1111;

  // Datapath source mux
  localparam logic [1:0] SEL_A    = 2'b00;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_IN   = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;

  // Bit positions inside the active-low load vector
  localparam int LD_A   = 0;
  localparam int LD_B   = 1;
  localparam int LD_OUT = 2;
  localparam int LD_PC  = 3;

  localparam logic [3:0] LD_NONE = 4'b1111;

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_TRAP  = 3'd3
`ifdef TD4_SINGLE_STEP_EN
    ,
    ST_WAIT_STEP = 3'd4
`endif
  } state_t;

endpackage
`default_nettype wire

// File: rtl/td4_op_decode.sv
`default_nettype none
// ============================================================================
// Module      : td4_op_decode
// Description : Combinational opcode decoder. Maps (op, carry flag) to the
//               source mux select, active-low load strobes, legality,
//               carry-write and jump-taken indications.
// Revision    : 1.0 - initial release
// ============================================================================
module td4_op_decode
  import td4_pkg::*;
(
  input  logic [3:0] i_op,
  input  logic       i_carry,
  output logic [1:0] o_sel,
  output logic [3:0] o_ld_n,
  output logic       o_legal,
  output logic       o_writes_carry,
  output logic       o_jump_taken
);

  // Opcode table; anything not listed is illegal and loads nothing
  always_comb begin
    o_sel          = SEL_ZERO;
    o_ld_n         = LD_NONE;
    o_legal        = 1'b1;
    o_writes_carry = 1'b0;
    o_jump_taken   = 1'b0;
    case (i_op)
      OP_ADD_A_IM: begin o_sel = SEL_A;    o_ld_n[LD_A]   = 1'b0; o_writes_carry = 1'b1; end
      OP_MOV_A_B:  begin o_sel = SEL_B;    o_ld_n[LD_A]   = 1'b0; end
      OP_IN_A:     begin o_sel = SEL_IN;   o_ld_n[LD_A]   = 1'b0; end
      OP_MOV_A_IM: begin o_sel = SEL_ZERO; o_ld_n[LD_A]   = 1'b0; end
      OP_MOV_B_A:  begin o_sel = SEL_A;    o_ld_n[LD_B]   = 1'b0; end
      OP_ADD_B_IM: begin o_sel = SEL_B;    o_ld_n[LD_B]   = 1'b0; o_writes_carry = 1'b1; end
      OP_IN_B:     begin o_sel = SEL_IN;   o_ld_n[LD_B]   = 1'b0; end
      OP_MOV_B_IM: begin o_sel = SEL_ZERO; o_ld_n[LD_B]   = 1'b0; end
      OP_OUT_B:    begin o_sel = SEL_B;    o_ld_n[LD_OUT] = 1'b0; end
      OP_OUT_IM:   begin o_sel = SEL_ZERO; o_ld_n[LD_OUT] = 1'b0; end
      OP_JNC_IM: begin
        o_sel = SEL_ZERO;
        if (!i_carry) begin
          o_ld_n[LD_PC] = 1'b0;
          o_jump_taken  = 1'b1;
        end
      end
      OP_JMP_IM: begin
        o_sel         = SEL_ZERO;
        o_ld_n[LD_PC] = 1'b0;
        o_jump_taken  = 1'b1;
      end
      default: o_legal = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/td4_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : td4_sequencer
// Description : Multi-cycle fetch/execute control unit for a TD4-class CPU.
//               Owns PC, IR and carry flag; fetches over a req/ack handshake
//               and drives datapath controls for one EXEC cycle per
//               instruction. Illegal opcodes trap until reset.
//               Optional macro TD4_SINGLE_STEP_EN adds step_i and a
//               WAIT_STEP state after every executed instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module td4_sequencer
  import td4_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int PC_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
`ifdef TD4_SINGLE_STEP_EN
  input  logic              step_i,
`endif
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W+3:0] imem_data,
  input  logic              carry_i,
  output logic [1:0]        sel,
  output logic [3:0]        ld_n,
  output logic [DATA_W-1:0] imm,
  output logic              carry_o,
  output logic              retire_o,
  output logic              illegal_o
);

  state_t              r_state;
  state_t              w_next_state;
  logic [PC_W-1:0]     r_pc;
  logic [DATA_W+3:0]   r_ir;
  logic                r_carry;
  logic                r_illegal;

  logic [3:0]          w_op;
  logic [PC_W-1:0]     w_imm_pc;
  logic [1:0]          w_dec_sel;
  logic [3:0]          w_dec_ld_n;
  logic                w_legal;
  logic                w_writes_carry;
  logic                w_jump_taken;
  logic                w_exec;

  assign w_op   = r_ir[DATA_W+3:DATA_W];
  assign w_exec = (r_state == ST_EXEC);

  // Jump target: immediate zero-extended or truncated to the PC width
  if (PC_W <= DATA_W) begin : g_imm_trunc
    assign w_imm_pc = r_ir[PC_W-1:0];
  end else begin : g_imm_zext
    assign w_imm_pc = {{(PC_W-DATA_W){1'b0}}, r_ir[DATA_W-1:0]};
  end

  // JNC looks at the flag as it stood before this EXEC cycle
  td4_op_decode u_decode (
    .i_op           (w_op),
    .i_carry        (r_carry),
    .o_sel          (w_dec_sel),
    .o_ld_n         (w_dec_ld_n),
    .o_legal        (w_legal),
    .o_writes_carry (w_writes_carry),
    .o_jump_taken   (w_jump_taken)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_BOOT;
    else       r_state <= w_next_state;
  end

  // Next-state logic; ack is only honoured while fetching
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_BOOT:  w_next_state = ST_FETCH;
      ST_FETCH: if (imem_ack) w_next_state = ST_EXEC;
      ST_EXEC: begin
        if (!w_legal) w_next_state = ST_TRAP;
`ifdef TD4_SINGLE_STEP_EN
        else          w_next_state = ST_WAIT_STEP;
`else
        else          w_next_state = ST_FETCH;
`endif
      end
      ST_TRAP:  w_next_state = ST_TRAP;
`ifdef TD4_SINGLE_STEP_EN
      ST_WAIT_STEP: if (step_i) w_next_state = ST_FETCH;
`endif
      default:  w_next_state = ST_BOOT;
    endcase
  end

  // Instruction register captures the fetched word on ack
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                r_ir <= '0;
    else if ((r_state == ST_FETCH) && imem_ack) r_ir <= imem_data;
  end

  // PC, carry and trap flag change only at the end of EXEC
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc      <= '0;
      r_carry   <= 1'b0;
      r_illegal <= 1'b0;
    end else if (w_exec) begin
      if (w_legal) begin
        r_pc    <= w_jump_taken ? w_imm_pc : r_pc + PC_W'(1);
        // Non-add instructions push zero through the adder, so carry clears
        r_carry <= w_writes_carry ? carry_i : 1'b0;
      end else begin
        r_illegal <= 1'b1;
      end
    end
  end

  // Outputs decoded from registered state and IR only
  always_comb begin
    imem_req = (r_state == ST_FETCH);
    sel      = SEL_ZERO;
    ld_n     = LD_NONE;
    retire_o = 1'b0;
    if (w_exec) begin
      sel      = w_dec_sel;
      ld_n     = w_dec_ld_n;
      retire_o = w_legal;
    end
  end

  assign imem_addr = r_pc;
  assign imm       = r_ir[DATA_W-1:0];
  assign carry_o   = r_carry;
  assign illegal_o = r_illegal;

endmodule
`default_nettype wire
